// File: rtl/serial_tx_unit_if.sv
// serial_tx_unit_if: handshake and serial-line bundle between the controller and
// the transmit unit.
//   sampleData : level, latch dataIn into the holding register (controller -> unit)
//   txData     : transmit request, rising edge starts a frame (controller -> unit)
//   dataIn     : parallel word from memory read-out (controller -> unit)
//   sout       : serial line, idles high (unit -> line)
//   txBusy     : frame in progress (unit -> controller)
//   txDone     : one-cycle end-of-frame pulse (unit -> controller)
interface serial_tx_unit_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  sampleData;
  logic                  txData;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  sout;
  logic                  txBusy;
  logic                  txDone;

  modport master (
    output sampleData,
    output txData,
    output dataIn,
    input  sout,
    input  txBusy,
    input  txDone
  );

  modport slave (
    input  sampleData,
    input  txData,
    input  dataIn,
    output sout,
    output txBusy,
    output txDone
  );
endinterface

// File: rtl/serial_tx_unit.sv
// serial_tx_unit: transmit end of the sampleData/txData/txDone handshake.
// Latches a parallel word on sampleData, and on a txData rising edge sends it
// as a UART-style frame on sout: start bit, DATA_WIDTH data bits LSB first,
// stop bit, each bit CLK_DIV clocks long. txDone pulses for one cycle at the
// end of the frame.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : serial_tx_unit_if.slave (sampleData, txData, dataIn in; sout, txBusy, txDone out)
// Optional: define SERIAL_TX_PARITY_EN to insert an even-parity bit between the
// last data bit and the stop bit.
module serial_tx_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input logic             clk,
  input logic             reset,
  serial_tx_unit_if.slave bus
);

  localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q;
  logic [7:0]            div_q;
  logic [BitW-1:0]       bit_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  txdata_q;

  logic                  tx_rise;
  logic                  div_last;
  logic                  bit_last;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] shift_next;

  assign tx_rise    = bus.txData & ~txdata_q;
  assign div_last   = (div_q == 8'(CLK_DIV - 1));
  assign bit_last   = (bit_q == BitW'(DATA_WIDTH - 1));
  // A sample on the same edge as the start request bypasses the holding register.
  assign load_word  = bus.sampleData ? bus.dataIn : hold_q;
  assign shift_next = shift_q >> 1;

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      hold_q     <= '0;
      shift_q    <= '0;
      // Reset high so a txData held high across reset release is not an edge.
      txdata_q   <= 1'b1;
      bus.sout   <= 1'b1;
      bus.txBusy <= 1'b0;
      bus.txDone <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      txdata_q   <= bus.txData;
      bus.txDone <= 1'b0;
      case (state_q)
        StIdle: begin
          bus.sout   <= 1'b1;
          bus.txBusy <= 1'b0;
          div_q      <= '0;
          bit_q      <= '0;
          if (bus.sampleData) begin
            hold_q <= bus.dataIn;
          end
          if (tx_rise) begin
            shift_q    <= load_word;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= ^load_word;
`endif
            state_q    <= StStart;
            bus.sout   <= 1'b0;
            bus.txBusy <= 1'b1;
          end
        end
        StStart: begin
          if (div_last) begin
            div_q    <= '0;
            state_q  <= StData;
            bus.sout <= shift_q[0];
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        StData: begin
          if (div_last) begin
            div_q <= '0;
            if (bit_last) begin
              bit_q    <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state_q  <= StParity;
              bus.sout <= parity_q;
`else
              state_q  <= StStop;
              bus.sout <= 1'b1;
`endif
            end else begin
              bit_q    <= bit_q + BitW'(1);
              shift_q  <= shift_next;
              bus.sout <= shift_next[0];
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        StParity: begin
          if (div_last) begin
            div_q    <= '0;
            state_q  <= StStop;
            bus.sout <= 1'b1;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
`endif
        StStop: begin
          if (div_last) begin
            div_q      <= '0;
            state_q    <= StIdle;
            bus.txBusy <= 1'b0;
            bus.txDone <= 1'b1;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: begin
          state_q    <= StIdle;
          bus.sout   <= 1'b1;
          bus.txBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_unit.sv
// Directed bench for serial_tx_unit at default parameters.
module tb_serial_tx_unit;

  localparam int unsigned DW  = 8;
  localparam int unsigned DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned FL = (DW + 3) * DIV;
`else
  localparam int unsigned FL = (DW + 2) * DIV;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  serial_tx_unit_if #(.DATA_WIDTH(DW)) bus ();

  serial_tx_unit #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected line level s cycles after the start edge for word w.
  function automatic logic exp_bit(int s, logic [7:0] w);
    int b;
    b = s / DIV;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
`ifdef SERIAL_TX_PARITY_EN
    if (b == DW + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Raise txData (optionally with a same-edge sample of w) and check the whole
  // frame cycle by cycle. inject_at >= 0 injects a sample of 8'hFF plus a
  // txData toggle mid-frame, which must be ignored.
  task automatic run_frame(input logic [7:0] w, input bit sample, input int inject_at,
                           input string tag);
    if (sample) begin
      bus.sampleData = 1'b1;
      bus.dataIn     = w;
    end
    bus.txData = 1'b1;
    for (int s = 0; s < int'(FL); s++) begin
      @(negedge clk);
      if (s == 0) bus.sampleData = 1'b0;
      chk({tag, ".sout"}, 32'(bus.sout), 32'(exp_bit(s, w)));
      chk({tag, ".busy"}, 32'(bus.txBusy), 32'd1);
      chk({tag, ".done_early"}, 32'(bus.txDone), 32'd0);
      if (inject_at >= 0) begin
        if (s == inject_at) begin
          bus.sampleData = 1'b1;
          bus.dataIn     = 8'hFF;
          bus.txData     = 1'b0;
        end else if (s == inject_at + 1) begin
          bus.sampleData = 1'b0;
          bus.txData     = 1'b1;
        end
      end
    end
    @(negedge clk);
    chk({tag, ".done"}, 32'(bus.txDone), 32'd1);
    chk({tag, ".busy_end"}, 32'(bus.txBusy), 32'd0);
    chk({tag, ".sout_end"}, 32'(bus.sout), 32'd1);
    bus.txData = 1'b0;
    bus.dataIn = 8'h00;
    @(negedge clk);
    chk({tag, ".done_once"}, 32'(bus.txDone), 32'd0);
    chk({tag, ".idle_sout"}, 32'(bus.sout), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b0;
    bus.sampleData = 1'b0;
    bus.txData     = 1'b1;
    bus.dataIn     = 8'h00;

    // Reset with txData held high: no frame after release.
    repeat (3) @(negedge clk);
    chk("rst.sout", 32'(bus.sout), 32'd1);
    chk("rst.busy", 32'(bus.txBusy), 32'd0);
    chk("rst.done", 32'(bus.txDone), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle.sout", 32'(bus.sout), 32'd1);
      chk("idle.busy", 32'(bus.txBusy), 32'd0);
      chk("idle.done", 32'(bus.txDone), 32'd0);
    end
    bus.txData = 1'b0;
    @(negedge clk);

    // Basic frame: sample A5, then start.
    bus.sampleData = 1'b1;
    bus.dataIn     = 8'hA5;
    @(negedge clk);
    bus.sampleData = 1'b0;
    bus.dataIn     = 8'h00;
    @(negedge clk);
    run_frame(8'hA5, 1'b0, -1, "basic");

    // Same-edge sample and start.
    run_frame(8'h3C, 1'b1, -1, "bypass");

    // Mid-frame sample of FF and txData toggle are ignored.
    run_frame(8'h3C, 1'b0, 10, "ignore");
    // Holding register still has 3C.
    run_frame(8'h3C, 1'b0, -1, "after_ignore");

    // Reset during data bit 3.
    bus.txData = 1'b1;
    for (int s = 0; s < 18; s++) begin
      @(negedge clk);
      if (s == 9) chk("abort.bit1", 32'(bus.sout), 32'd0);
      if (s == 17) chk("abort.bit3", 32'(bus.sout), 32'd1);
    end
    #1 reset = 1'b0;
    #1;
    chk("abort.sout", 32'(bus.sout), 32'd1);
    chk("abort.busy", 32'(bus.txBusy), 32'd0);
    chk("abort.done", 32'(bus.txDone), 32'd0);
    @(negedge clk);
    bus.txData = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      chk("abort.no_done", 32'(bus.txDone), 32'd0);
      chk("abort.no_busy", 32'(bus.txBusy), 32'd0);
    end
    run_frame(8'h00, 1'b0, -1, "post_reset");

    // Word 07: odd popcount, parity bit 1 when parity is enabled.
    bus.sampleData = 1'b1;
    bus.dataIn     = 8'h07;
    @(negedge clk);
    bus.sampleData = 1'b0;
    @(negedge clk);
    run_frame(8'h07, 1'b0, -1, "w07");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_unit.md
Name: serial_tx_unit

Overview:
- Transmit end of the controller's sampleData/txData/txDone handshake.
- On sampleData, captures the parallel word from memory read-out.
- On a txData rising edge, serialises the word as a UART-style frame on sout (start bit, data LSB first, stop bit).
- Returns a one-cycle txDone pulse to the controller when the frame completes.

Parameters:
- DATA_WIDTH, 8, width of dataIn and of the data field of the frame.
- CLK_DIV, 4, clock cycles per serial bit (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sampleData  input  1  level; when high at a clock edge in IDLE, dataIn is latched into the holding register.
- txData  input  1  transmit request; only its rising edge starts a frame.
- dataIn  input  DATA_WIDTH  parallel word from memory.
- sout  output  1  serial line; idle level 1.
- txBusy  output  1  high while a frame is in progress.
- txDone  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values (reset=0, asynchronous):
  - sout=1, txBusy=0, txDone=0.
  - Holding register = 0, state=IDLE, bit and divider counters = 0.
  - txData edge register = 1, so a txData held high through reset release does not start a frame.
- States: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - sout=1, txBusy=0.
  - sampleData=1 loads dataIn into the holding register.
  - A txData rising edge (txData=1, previous=0) loads the shift register from the holding register, then state goes to START.
  - If sampleData=1 and the rising edge occur on the same edge, the shift register loads dataIn directly (bypass); the holding register is also updated.
- START: sout=0 for CLK_DIV cycles, then DATA.
- DATA:
  - sout = shift register bit 0, held for CLK_DIV cycles, then shift right.
  - After DATA_WIDTH bits, go to STOP.
- STOP: sout=1 for CLK_DIV cycles.
  - On the final STOP cycle edge, state goes to IDLE and txDone=1 for exactly one cycle.
- txBusy: 1 in START, DATA and STOP; 0 in the txDone cycle.
- Latency:
  - sout falls on the cycle after the txData rising edge.
  - txDone is asserted (DATA_WIDTH+2)*CLK_DIV cycles after sout falls (40 cycles at defaults).
- Divider counter counts 0..CLK_DIV-1. Bit counter width is clog2(DATA_WIDTH+1).
- Requests during a frame (not IDLE): txData edges and sampleData are ignored. No queueing; the holding register is unchanged.
- Back-to-back frames:
  - A new frame needs txData to fall and rise again after txDone.
  - A rise on the cycle after txDone is accepted, so the minimum gap is 1 cycle of sout=1 beyond the stop bit.
- Reset mid-frame: the frame aborts immediately, sout returns to 1, and no txDone is issued.
- CLK_DIV=1: each bit lasts one cycle, and the frame follows the same rules.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - sout = even parity (XOR of all data bits of the transmitted word) for CLK_DIV cycles.
  - Frame length becomes (DATA_WIDTH+3)*CLK_DIV (44 cycles at defaults), and txDone timing shifts accordingly.
- Undefined: no parity state or logic; frame as described in Behaviour.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release with txData=1 held -> sout=1, txBusy=0, txDone=0, no frame for 50 cycles.
- Basic frame (defaults):
  - Stimulus: sampleData pulse with dataIn=8'hA5, then txData rises.
  - sout = 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles).
  - txDone is a single pulse 40 cycles after sout falls; txBusy=1 throughout the frame.
- Simultaneous sample and start: sampleData=1, dataIn=8'h3C and txData rising on the same edge -> transmitted data bits 0,0,1,1,1,1,0,0.
- Ignored requests:
  - Stimulus: mid-frame, sampleData with dataIn=8'hFF plus a txData toggle.
  - Required: the current frame is unchanged, only one txDone, and a later frame without a new sample still sends the old word.
- Reset mid-frame: assert reset during DATA bit 3 -> sout=1 immediately, no txDone, and the next txData edge sends a frame with data 8'h00.
- Parity (SERIAL_TX_PARITY_EN defined): dataIn=8'h07 -> parity bit = 1, stop bit follows, txDone 44 cycles after sout falls.
